// File: rtl/quad_position_decoder_if.sv
// Quadrature decoder bus interface.
// Bundles the control inputs (en, clr_pos), the raw phase lines (a_in, b_in) and the decoded
// outputs (pos, dir, step_pulse, err_pulse, err_count, moving).
//   master : drives en/clr_pos/a_in/b_in and observes the decoded outputs
//   slave  : the decoder itself
interface quad_position_decoder_if #(
  parameter int unsigned POS_WIDTH = 16
);
  logic                 en;
  logic                 clr_pos;
  logic                 a_in;
  logic                 b_in;
  logic [POS_WIDTH-1:0] pos;
  logic [1:0]           dir;
  logic                 step_pulse;
  logic                 err_pulse;
  logic [7:0]           err_count;
  logic                 moving;

  modport master (
    output en, clr_pos, a_in, b_in,
    input  pos, dir, step_pulse, err_pulse, err_count, moving
  );

  modport slave (
    input  en, clr_pos, a_in, b_in,
    output pos, dir, step_pulse, err_pulse, err_count, moving
  );
endinterface

// File: rtl/quad_position_decoder.sv
// Quadrature position decoder.
// Synchronises raw A/B phase lines, glitch-filters them, decodes the Gray sequence
// 00->01->11->10->00 into a signed position with direction, step and error events, and returns
// dir to idle after a period without activity.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : quad_position_decoder_if.slave
//          en, clr_pos, a_in, b_in in; pos, dir, step_pulse, err_pulse, err_count, moving out
module quad_position_decoder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_LEN   = 3,
  parameter int unsigned POS_WIDTH    = 16,
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  quad_position_decoder_if.slave bus
);

  localparam int unsigned FcW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] DirIdle = 2'b00;
  localparam logic [1:0] DirCw   = 2'b01;
  localparam logic [1:0] DirCcw  = 2'b10;
  localparam logic [1:0] DirErr  = 2'b11;

  function automatic logic [1:0] gray_next(input logic [1:0] v);
    logic [1:0] r;
    unique case (v)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Synchronisers. vld_q marks stages that hold a real sample, so the cleared flops are never
  // mistaken for an input level of 00 right after reset.
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q, vld_q;
  logic [1:0]             sync_ab;
  logic                   sync_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      vld_q    <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b_in};
      vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ab  = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign sync_vld = vld_q[SYNC_STAGES-1];

  // Glitch filter. filt_vld_q is clear after reset so the first stable level is accepted even
  // when it equals the cleared value; that first acceptance only primes the decoder.
  logic [1:0]     filt_q, filt_d, cand_q, cand_d;
  logic           filt_vld_q, filt_vld_d, acc_q, acc_d;
  logic [FcW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d     = filt_q;
    filt_vld_d = filt_vld_q;
    cand_d     = cand_q;
    cnt_d      = '0;
    acc_d      = 1'b0;
    if (sync_vld && (!filt_vld_q || sync_ab != filt_q)) begin
      cand_d = sync_ab;
      if (cnt_q != '0 && sync_ab == cand_q) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = FcW'(1);
      end
      if (cnt_d == FcW'(FILTER_LEN)) begin
        filt_d     = sync_ab;
        filt_vld_d = 1'b1;
        acc_d      = 1'b1;
        cnt_d      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 2'b00;
      filt_vld_q <= 1'b0;
      cand_q     <= 2'b00;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_vld_q <= filt_vld_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
    end
  end

  // Decoder. Acts one cycle after a level is accepted. prev_q always follows accepted levels,
  // even with en low, so re-enabling never produces an event for motion that happened meanwhile.
  logic [1:0]           prev_q, prev_d, dir_q, dir_d;
  logic                 primed_q, primed_d, step_q, step_d, err_q, err_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [7:0]           errcnt_q, errcnt_d;
  logic [ToW-1:0]       idle_q, idle_d;
  logic                 live, fwd, rev, bad;

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    idle_d   = idle_q;

    live = acc_q && primed_q;
    fwd  = live && (filt_q == gray_next(prev_q));
    rev  = live && (prev_q == gray_next(filt_q));
    bad  = live && ((filt_q ^ prev_q) == 2'b11);

    if (acc_q) begin
      prev_d   = filt_q;
      primed_d = 1'b1;
    end

    // With en low, pulses simply stay low; everything else holds.
    if (bus.en) begin
      if (fwd) begin
        pos_d  = pos_q + 1'b1;
        dir_d  = DirCw;
        step_d = 1'b1;
        idle_d = '0;
      end else if (rev) begin
        pos_d  = pos_q - 1'b1;
        dir_d  = DirCcw;
        step_d = 1'b1;
        idle_d = '0;
      end else if (bad) begin
        dir_d  = DirErr;
        err_d  = 1'b1;
        idle_d = '0;
        if (errcnt_q != 8'hFF) begin
          errcnt_d = errcnt_q + 1'b1;
        end
      end else if (idle_q != ToW'(IDLE_TIMEOUT)) begin
        idle_d = idle_q + 1'b1;
        if (idle_d == ToW'(IDLE_TIMEOUT)) begin
          dir_d = DirIdle;
        end
      end
    end

    // The clear beats a coincident step; step_pulse and dir still report the step.
    if (bus.clr_pos) begin
      pos_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      pos_q    <= '0;
      dir_q    <= DirIdle;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'h00;
      idle_q   <= '0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.pos        = pos_q;
  assign bus.dir        = dir_q;
  assign bus.step_pulse = step_q;
  assign bus.err_pulse  = err_q;
  assign bus.err_count  = errcnt_q;
  assign bus.moving     = dir_q[0] ^ dir_q[1];

endmodule

// File: tb/tb_quad_position_decoder.sv
// Testbench for quad_position_decoder: a 16-bit instance plus a 4-bit instance fed with the
// same stimulus (the narrow one exercises position wrap cheaply), a behavioural model, an
// every-cycle compare process and directed checks with literal expectations.
module tb_quad_position_decoder;
  localparam int unsigned S  = 2;
  localparam int unsigned F  = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned T  = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_position_decoder_if #(.POS_WIDTH(W))  bus ();
  quad_position_decoder_if #(.POS_WIDTH(NW)) bus_n ();

  assign bus_n.en      = bus.en;
  assign bus_n.clr_pos = bus.clr_pos;
  assign bus_n.a_in    = bus.a_in;
  assign bus_n.b_in    = bus.b_in;

  quad_position_decoder #(
    .SYNC_STAGES(S), .FILTER_LEN(F), .POS_WIDTH(W), .IDLE_TIMEOUT(T)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  quad_position_decoder #(
    .SYNC_STAGES(S), .FILTER_LEN(F), .POS_WIDTH(NW), .IDLE_TIMEOUT(T)
  ) u_dut_narrow (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int step_seen = 0;
  int err_seen  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of a Gray code within the cycle 00,01,11,10.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Behavioural model: sync = raw sample delayed S edges; a level is accepted once the last F
  // sync samples agree and differ from the accepted level; events follow one edge later.
  logic [1:0]   raw_hist[$];
  logic [1:0]   win[$];
  logic [1:0]   m_filt, m_prev, m_acc_val, m_syn;
  bit           m_fvld, m_acc_pend, m_primed, m_step, m_err, m_ev, m_same;
  logic [W-1:0] m_pos;
  logic [1:0]   m_dir;
  int           m_errcnt, m_since, m_delta;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      raw_hist.delete();
      win.delete();
      m_fvld = 0; m_acc_pend = 0; m_primed = 0; m_prev = 2'b00; m_filt = 2'b00;
      m_pos = '0; m_dir = 2'b00; m_step = 0; m_err = 0; m_errcnt = 0; m_since = 0;
    end else begin
      m_step = 0;
      m_err  = 0;
      m_ev   = 0;
      if (m_acc_pend) begin
        if (m_primed && bus.en) begin
          m_delta = (gidx(m_acc_val) - gidx(m_prev) + 4) % 4;
          if (m_delta == 1) begin
            m_pos = m_pos + 1'b1; m_dir = 2'b01; m_step = 1; m_ev = 1;
          end else if (m_delta == 3) begin
            m_pos = m_pos - 1'b1; m_dir = 2'b10; m_step = 1; m_ev = 1;
          end else if (m_delta == 2) begin
            m_dir = 2'b11; m_err = 1; m_ev = 1;
            if (m_errcnt < 255) m_errcnt++;
          end
        end
        m_prev   = m_acc_val;
        m_primed = 1;
      end
      if (bus.en) begin
        if (m_ev) m_since = 0;
        else if (m_since < T) begin
          m_since++;
          if (m_since == T) m_dir = 2'b00;
        end
      end
      if (bus.clr_pos) m_pos = '0;

      m_acc_pend = 0;
      if (raw_hist.size() >= S) begin
        m_syn = raw_hist[raw_hist.size() - S];
        win.push_back(m_syn);
        if (win.size() > F) void'(win.pop_front());
        m_same = (win.size() == F);
        foreach (win[i]) if (win[i] != m_syn) m_same = 0;
        if (m_same && (!m_fvld || m_syn != m_filt)) begin
          m_filt = m_syn; m_fvld = 1; m_acc_pend = 1; m_acc_val = m_syn;
        end
      end
      raw_hist.push_back({bus.a_in, bus.b_in});
      if (raw_hist.size() > S) void'(raw_hist.pop_front());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("pos",        32'(bus.pos),        32'(m_pos));
      check("pos_narrow", 32'(bus_n.pos),      32'(m_pos[NW-1:0]));
      check("dir",        32'(bus.dir),        32'(m_dir));
      check("step_pulse", 32'(bus.step_pulse), 32'(m_step));
      check("err_pulse",  32'(bus.err_pulse),  32'(m_err));
      check("err_count",  32'(bus.err_count),  32'(m_errcnt));
      check("moving",     32'(bus.moving),     32'(m_dir == 2'b01 || m_dir == 2'b10));
      check("pulse_excl", 32'(bus.step_pulse & bus.err_pulse), 32'd0);
      if (bus.step_pulse) step_seen++;
      if (bus.err_pulse)  err_seen++;
    end
  end

  logic [1:0] gcode [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int cur;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input int idx, input int hold);
    cur = idx & 3;
    bus.a_in = gcode[cur][1];
    bus.b_in = gcode[cur][0];
    tick(hold);
  endtask

  int lat, s0, e0, r;

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.clr_pos = 1'b0; bus.a_in = 1'b0; bus.b_in = 1'b0; cur = 0;
    tick(3);
    chk_en = 1'b1;
    check("reset_pos", 32'(bus.pos), 32'd0);
    check("reset_dir", 32'(bus.dir), 32'd0);
    rst = 1'b0;
    tick(10);

    // Forward sequence with latency measurement on the first step.
    s0 = step_seen;
    cur = 1; bus.a_in = 1'b0; bus.b_in = 1'b1;
    lat = 0;
    do begin tick(1); lat++; end while (!bus.step_pulse && lat < 20);
    check("first_step_latency", 32'(lat), 32'd6);
    tick(10 - lat);
    go(2, 10); go(3, 10); go(0, 10);
    check("fwd_pos", 32'(bus.pos), 32'd4);
    check("fwd_dir", 32'(bus.dir), 32'd1);
    check("fwd_errcnt", 32'(bus.err_count), 32'd0);
    check("fwd_steps", 32'(step_seen - s0), 32'd4);

    // Reverse six steps through zero, then idle timeout.
    for (int i = 1; i <= 5; i++) go(cur - 1, 10);
    check("rev_wrap_ffff", 32'(bus.pos), 32'h0000FFFF);
    go(cur - 1, 10);
    check("rev_pos", 32'(bus.pos), 32'h0000FFFE);
    check("rev_dir", 32'(bus.dir), 32'd2);
    tick(T);
    check("timeout_dir", 32'(bus.dir), 32'd0);
    check("timeout_moving", 32'(bus.moving), 32'd0);

    // Glitches on a_in while at 00.
    go(cur + 1, 10); go(cur + 1, 10);
    check("pre_glitch_pos", 32'(bus.pos), 32'd0);
    s0 = step_seen;
    bus.a_in = 1'b1; tick(1); bus.a_in = 1'b0; tick(8);
    bus.a_in = 1'b1; tick(2); bus.a_in = 1'b0; tick(8);
    check("glitch_steps", 32'(step_seen - s0), 32'd0);
    check("glitch_pos", 32'(bus.pos), 32'd0);
    bus.a_in = 1'b1; tick(3); bus.a_in = 1'b0; tick(10);
    check("hold3_steps", 32'(step_seen - s0), 32'd2);

    // Illegal jumps.
    e0 = err_seen;
    go(2, 10);
    check("illegal_errs", 32'(err_seen - e0), 32'd1);
    check("illegal_dir", 32'(bus.dir), 32'd3);
    check("illegal_errcnt", 32'(bus.err_count), 32'd1);
    check("illegal_pos", 32'(bus.pos), 32'd0);
    for (int i = 0; i < 299; i++) go(cur + 2, 4);
    tick(6);
    check("errcnt_sat", 32'(bus.err_count), 32'd255);
    check("errs_pos", 32'(bus.pos), 32'd0);
    tick(T);
    check("err_timeout_dir", 32'(bus.dir), 32'd0);

    // Narrow instance: +7 -> +8 wraps to the most negative value.
    for (int i = 0; i < 7; i++) go(cur + 1, 6);
    tick(6);
    check("narrow_max", 32'(bus_n.pos), 32'h7);
    go(cur + 1, 10);
    check("narrow_wrap", 32'(bus_n.pos), 32'h8);
    check("wide_eight", 32'(bus.pos), 32'd8);

    // Clear coinciding with a step.
    go(cur + 1, 5);
    bus.clr_pos = 1'b1; tick(1); bus.clr_pos = 1'b0;
    check("clr_step_pos", 32'(bus.pos), 32'd0);
    check("clr_step_pulse", 32'(bus.step_pulse), 32'd1);
    tick(5);

    // Reset with inputs at 11: re-prime only.
    cur = 2; bus.a_in = 1'b1; bus.b_in = 1'b1; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    s0 = step_seen; e0 = err_seen;
    tick(15);
    check("rst11_steps", 32'(step_seen - s0), 32'd0);
    check("rst11_errs", 32'(err_seen - e0), 32'd0);
    check("rst11_pos", 32'(bus.pos), 32'd0);

    // Disable over three steps.
    go(cur + 1, 10);
    check("en_pre_pos", 32'(bus.pos), 32'd1);
    bus.en = 1'b0;
    go(cur + 1, 10); go(cur + 1, 10); go(cur + 1, 10);
    bus.en = 1'b1;
    tick(2);
    check("en_frozen_pos", 32'(bus.pos), 32'd1);
    go(cur + 1, 10);
    check("en_resume_pos", 32'(bus.pos), 32'd2);

    // Randomized phase.
    repeat (600) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1; tick(1); rst = 1'b0;
      end else if (r < 8) begin
        bus.en = ~bus.en;
      end else if (r < 12) begin
        bus.clr_pos = 1'b1; tick(1); bus.clr_pos = 1'b0;
      end
      r = int'($urandom_range(0, 99));
      if (r < 45)      go(cur + 1, int'($urandom_range(1, 8)));
      else if (r < 85) go(cur - 1, int'($urandom_range(1, 8)));
      else if (r < 92) go(cur + 2, int'($urandom_range(1, 8)));
      else             go(cur, int'($urandom_range(1, 8)));
    end
    bus.en = 1'b1;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
